// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shared 32-step shift/add and restoring-divide datapath.
// Define MULDIV_EARLY_OUT_EN to skip the iterations for zero-operand multiplies, divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic [2:0]        f3_reg;
  logic [XLEN-1:0]   opd_reg;
  logic [XLEN-1:0]   acc_hi_reg;
  logic [XLEN-1:0]   acc_lo_reg;
  logic              neg_reg;
  logic              rem_neg_reg;
  logic              div_zero_reg;

  logic              is_mul_in;
  logic              a_signed_in;
  logic              b_signed_in;
  logic              a_neg_in;
  logic              b_neg_in;
  logic [XLEN-1:0]   a_mag_in;
  logic [XLEN-1:0]   b_mag_in;
  logic              div_zero_in;
  logic              early_in;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_result;

  // Operand decode at accept: signed operands are reduced to magnitudes.
  always_comb begin
    is_mul_in   = ~funct3[2];
    a_signed_in = is_mul_in ? (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10) : ~funct3[0];
    b_signed_in = is_mul_in ? (funct3[1:0] == 2'b01) : ~funct3[0];
    a_neg_in    = a_signed_in & operand_a[XLEN-1];
    b_neg_in    = b_signed_in & operand_b[XLEN-1];
    a_mag_in    = a_neg_in ? -operand_a : operand_a;
    b_mag_in    = b_neg_in ? -operand_b : operand_b;
    div_zero_in = funct3[2] & (operand_b == '0);
    early_in    = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
    if (is_mul_in)
      early_in = (operand_a == '0) || (operand_b == '0);
    else
      early_in = div_zero_in ||
                 (~funct3[0] && operand_a == {1'b1, {(XLEN-1){1'b0}}} && operand_b == '1);
`endif
  end

  // Iteration step and final sign correction.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opd_reg} : '0);
    div_shift = {acc_hi_reg, acc_lo_reg[XLEN-1]};
    div_ok    = div_shift >= {1'b0, opd_reg};
    div_diff  = div_shift - {1'b0, opd_reg};
    prod      = {acc_hi_reg, acc_lo_reg};
    prod_fix  = neg_reg ? -prod : prod;
    // Divide by zero yields all ones whatever the dividend sign.
    quo_fix   = div_zero_reg ? '1 : (neg_reg ? -acc_lo_reg : acc_lo_reg);
    rem_fix   = rem_neg_reg ? -acc_hi_reg : acc_hi_reg;
    case (f3_reg)
      3'b000:                 fix_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = quo_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      f3_reg       <= '0;
      opd_reg      <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      neg_reg      <= 1'b0;
      rem_neg_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      rd_out       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            busy         <= 1'b1;
            f3_reg       <= funct3;
            rd_out       <= rd_in;
            cnt_reg      <= '0;
            neg_reg      <= a_neg_in ^ b_neg_in;
            rem_neg_reg  <= a_neg_in & funct3[2];
            div_zero_reg <= div_zero_in;
            opd_reg      <= is_mul_in ? a_mag_in : b_mag_in;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= is_mul_in ? b_mag_in : a_mag_in;
            state_reg    <= RUN;
            if (early_in) begin
              // Preload the final magnitudes so FIX produces the special-case result.
              acc_hi_reg <= div_zero_in ? a_mag_in : '0;
              acc_lo_reg <= is_mul_in ? '0 : a_mag_in;
              state_reg  <= FIX;
            end
          end
        end
        RUN: begin
          if (!f3_reg[2]) begin
            acc_hi_reg <= mul_sum[XLEN:1];
            acc_lo_reg <= {mul_sum[0], acc_lo_reg[XLEN-1:1]};
          end else begin
            acc_hi_reg <= div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            acc_lo_reg <= {acc_lo_reg[XLEN-2:0], div_ok};
          end
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(ITER - 1))
            state_reg <= FIX;
        end
        FIX: begin
          result    <= fix_result;
          done      <= 1'b1;
          state_reg <= DONE;
        end
        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
